reg_serial_reader: RTL

// - Consumer end of the 8-bit register datapath: takes a parallel word held in a register, frames it and shifts it out on one line.
// - Frame is UART-style: start bit, WIDTH data bits LSB first, stop bit.
// - Sits between the register bank and the board I/O pin, so register contents can be read off-chip by a serial monitor or logic analyser.

---
 rtl/reg_serial_pkg.sv | 29 ++
 rtl/bit_tick_gen.sv | 43 ++++
 rtl/reg_serial_reader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/reg_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_serial_pkg
//  Description : Shared types and constants for the register serial reader.
//                The package holds the frame FSM state type, the line idle
//                level and a helper that sizes counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_serial_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } sr_state_t;

    // Level of the serial line when no frame is in progress.
    // This is also the level of the stop bit.
    localparam logic SR_IDLE_LEVEL = 1'b1;

    // Width of a counter that must hold values 0..n-1. The result is never below 1 bit.
    function automatic int sr_width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bit_tick_gen
//  Description : Bit-period divider. While 'run' is high it counts
//                0..DIV-1 and raises 'tick' in the last cycle of each
//                period, then wraps. The counter is held at zero while idle,
//                so the first period after start is always a full DIV cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_tick_gen
    import reg_serial_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int              CW     = sr_width_of(DIV);
    localparam logic [CW-1:0]   c_last = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == c_last);
    assign tick      = run && w_at_last;

    // Divider counter: it cleared on abort, when idle, or on wrap, and otherwise advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || !run || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_serial_reader.sv
`default_nettype none
// ============================================================================
//  Module      : reg_serial_reader
//  Description : Frames a parallel register word as start bit, WIDTH data
//                bits (LSB first) and stop bit, and then shifts the frame out on
//                SR_SDO at DIV clocks per bit. SR_SDO and SR_BUSY come from
//                registers, so the pin does not glitch. SR_LD_READY is a decode
//                of the state. SR_DONE marks the final cycle of a frame that
//                completes without an abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_serial_reader
    import reg_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             SR_CLK,
    input  logic             SR_RST_N,
    input  logic             SR_CLR,
    input  logic             SR_LD_VALID,
    output logic             SR_LD_READY,
    input  logic [WIDTH-1:0] SR_D,
    output logic             SR_SDO,
    output logic             SR_BUSY,
    output logic             SR_DONE
);

    localparam int            IW         = sr_width_of(WIDTH);
    localparam logic [IW-1:0] c_last_idx = IW'(WIDTH - 1);

    sr_state_t        r_state;
    sr_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nxt;
    logic             r_sdo;
    logic             w_sdo_nxt;
    logic             r_busy;
    logic             w_run;
    logic             w_tick;
    logic             w_done;

    // The divider runs for the whole frame and is held at zero in IDLE
    assign w_run = (r_state != IDLE);

    bit_tick_gen #(
        .DIV   (DIV)
    ) u_bit_tick_gen (
        .clk   (SR_CLK),
        .rst_n (SR_RST_N),
        .clr   (SR_CLR),
        .run   (w_run),
        .tick  (w_tick)
    );

    // Next-state, datapath and line-level decode. The line level is computed
    // from the *next* state so that the registered pin matches the state
    // held during the following cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_done      = 1'b0;
        w_sdo_nxt   = SR_IDLE_LEVEL;

        if (SR_CLR) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (SR_LD_VALID) begin
                        w_state_nxt = START;
                        w_shift_nxt = SR_D;
                        w_idx_nxt   = '0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        w_state_nxt = DATA;
                        w_idx_nxt   = '0;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        w_shift_nxt = r_shift >> 1;
                        w_idx_nxt   = r_idx + IW'(1);
                        if (r_idx == c_last_idx) begin
                            w_state_nxt = STOP;
                            w_idx_nxt   = '0;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        w_state_nxt = IDLE;
                        w_done      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        case (w_state_nxt)
            START:   w_sdo_nxt = ~SR_IDLE_LEVEL;
            DATA:    w_sdo_nxt = w_shift_nxt[0];
            default: w_sdo_nxt = SR_IDLE_LEVEL;
        endcase
    end

    // State register
    always_ff @(posedge SR_CLK or negedge SR_RST_N) begin
        if (!SR_RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registers for the shift register, the bit index and the two pin-facing outputs
    always_ff @(posedge SR_CLK or negedge SR_RST_N) begin
        if (!SR_RST_N) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_sdo   <= SR_IDLE_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_sdo   <= w_sdo_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign SR_LD_READY = (r_state == IDLE);
    assign SR_SDO      = r_sdo;
    assign SR_BUSY     = r_busy;
    assign SR_DONE     = w_done;

endmodule
`default_nettype wire
